// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the data-memory responder.
// Holds the FSM state encoding, default geometry and latency limits.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = 32;

    // Largest supported request-to-response latency.
    localparam int LAT_MAX = 16;

    // The countdown only ever holds LATENCY-2, so 4 bits cover LAT_MAX.
    localparam int CNT_W = $clog2(LAT_MAX);

    // Index width needed to address DEPTH words (at least one bit).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x DATA_W word array: synchronous write, registered read,
// synchronous clear of every word and of the read register.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high clear of all words and rdata
//   we      write wdata to mem[addr] at the edge
//   re      capture mem[addr] into rdata at the edge
//   addr    word index (caller guarantees addr < DEPTH when we/re)
//   wdata   write data
//   rdata   registered read data, held between reads
module data_mem_array
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = idx_width(DEF_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we) begin
                mem_q[addr] <= wdata;
            end
            if (re) begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's data port: one request at a
// time, fixed LATENCY, single response beat held until rsp_ready.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_write             1 = store, 0 = load
//   req_addr, req_wdata   word index and store data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             load data (0 for stores and errors)
//   rsp_err               address was >= DEPTH
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = idx_width(DEPTH);

    // DEPTH may equal 2^ADDR_W, so compare with one extra bit.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    localparam logic [CNT_W-1:0] CNT_INIT =
        (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              load_ok_q;

    logic              accept_d;
    logic              enter_resp_d;
    logic              acc_write_d;
    logic [ADDR_W-1:0] acc_addr_d;
    logic [DATA_W-1:0] acc_wdata_d;
    logic              in_range_d;
    logic              mem_we_d;
    logic              mem_re_d;
    logic [DATA_W-1:0] arr_rdata;

    // With LATENCY=1 the array is accessed on the accept edge itself,
    // before the request has been latched, so the live inputs are used
    // while idle and the latched copy otherwise.
    always_comb begin
        accept_d     = (state_q == ST_IDLE) && req_valid && req_ready_q;
        enter_resp_d = 1'b0;
        if (state_q == ST_IDLE) begin
            enter_resp_d = accept_d && (LATENCY == 1);
        end else if (state_q == ST_BUSY) begin
            enter_resp_d = (cnt_q == '0);
        end
        if (state_q == ST_IDLE) begin
            acc_write_d = req_write;
            acc_addr_d  = req_addr;
            acc_wdata_d = req_wdata;
        end else begin
            acc_write_d = wr_q;
            acc_addr_d  = addr_q;
            acc_wdata_d = wdata_q;
        end
        in_range_d = ({1'b0, acc_addr_d} < DEPTH_L);
        mem_we_d   = !rst && enter_resp_d && acc_write_d && in_range_d;
        mem_re_d   = !rst && enter_resp_d && !acc_write_d && in_range_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            load_ok_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        wr_q        <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        cnt_q       <= CNT_INIT;
                        state_q     <= (LATENCY == 1) ? ST_RESP : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        load_ok_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
            // Response fields are captured once, on the edge into RESP.
            if (enter_resp_d) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= !in_range_d;
                load_ok_q   <= !acc_write_d && in_range_d;
            end
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we_d),
        .re    (mem_re_d),
        .addr  (acc_addr_d[IDX_W-1:0]),
        .wdata (acc_wdata_d),
        .rdata (arr_rdata)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    // The array read register holds the last load; stores and errors
    // present zero instead.
    assign rsp_rdata = load_ok_q ? arr_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances
// (LATENCY 2/DEPTH 20, LATENCY 1, LATENCY 4) driven by directed vectors.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst       [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_write [3];
    logic [4:0]  req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    logic [32:0] exp_q [3][$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit done = 1'b0;

    bit          rst_prev  [3] = '{0, 0, 0};
    bit          hs_prev   [3] = '{0, 0, 0};
    bit          hold_prev [3] = '{0, 0, 0};
    bit          vld_prev  [3] = '{0, 0, 0};
    bit          pend      [3] = '{0, 0, 0};
    int          acc       [3] = '{0, 0, 0};
    logic [31:0] sv_rd     [3];
    logic        sv_err    [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        localparam int D = (g == 0) ? 20 : 32;
        data_mem_responder #(
            .DATA_W  (32),
            .ADDR_W  (5),
            .DEPTH   (D),
            .LATENCY (L)
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );
    end

    function automatic int lat_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a request and return just after the edge that accepts it.
    task automatic send(input int g, input bit wr, input logic [4:0] a,
                        input logic [31:0] wd, input bit chk,
                        input bit e_err, input logic [31:0] e_rd);
        if (chk) exp_q[g].push_back({e_err, e_rd});
        req_valid[g] = 1'b1;
        req_write[g] = wr;
        req_addr[g]  = a;
        req_wdata[g] = wd;
        while (!req_ready[g]) tick(1);
        tick(1);
    endtask

    task automatic idle(input int g);
        req_valid[g] = 1'b0;
    endtask

    task automatic drain(input int g);
        while (exp_q[g].size() != 0) tick(1);
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            rst[g]       = 1'b1;
            req_valid[g] = 1'b0;
            req_write[g] = 1'b0;
            req_addr[g]  = '0;
            req_wdata[g] = '0;
            rsp_ready[g] = 1'b1;
        end
        tick(2);
        for (int g = 0; g < 3; g++) rst[g] = 1'b0;
        tick(1);

        // Store then load on LATENCY=2.
        send(0, 1, 5'd3, 32'hDEADBEEF, 1, 0, 32'h0);
        idle(0);
        drain(0);
        send(0, 0, 5'd3, 32'h0, 1, 0, 32'hDEADBEEF);
        idle(0);
        drain(0);

        // Back-pressure: response held for several cycles.
        rsp_ready[0] = 1'b0;
        send(0, 0, 5'd3, 32'h0, 1, 0, 32'hDEADBEEF);
        idle(0);
        tick(7);
        rsp_ready[0] = 1'b1;
        drain(0);

        // Out of range on DEPTH=20; word 5 must survive.
        send(0, 1, 5'd5, 32'h55555555, 1, 0, 32'h0);
        send(0, 1, 5'd25, 32'h12345678, 1, 1, 32'h0);
        send(0, 0, 5'd25, 32'h0, 1, 1, 32'h0);
        send(0, 0, 5'd5, 32'h0, 1, 0, 32'h55555555);
        idle(0);
        drain(0);

        // Inputs changed while busy are ignored.
        send(0, 1, 5'd9, 32'hCAFEF00D, 1, 0, 32'h0);
        idle(0);
        req_addr[0]  = 5'd10;
        req_wdata[0] = 32'hBAD0BAD0;
        drain(0);
        send(0, 0, 5'd9, 32'h0, 1, 0, 32'hCAFEF00D);
        idle(0);
        req_addr[0] = 5'd3;
        drain(0);
        send(0, 0, 5'd10, 32'h0, 1, 0, 32'h0);
        idle(0);
        drain(0);

        // LATENCY=1 back-to-back with req_valid held high.
        for (int i = 0; i < 4; i++) begin
            send(1, 1, 5'(i), 32'((i + 1) * 16), 1, 0, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            send(1, 0, 5'(i), 32'h0, 1, 0, 32'((i + 1) * 16));
        end
        idle(1);
        drain(1);

        // Reset in BUSY on LATENCY=4 drops the store and clears memory.
        send(2, 1, 5'd7, 32'h00000011, 1, 0, 32'h0);
        idle(2);
        drain(2);
        send(2, 1, 5'd7, 32'hAAAA5555, 0, 0, 32'h0);
        idle(2);
        tick(1);
        rst[2] = 1'b1;
        tick(1);
        rst[2] = 1'b0;
        send(2, 0, 5'd7, 32'h0, 1, 0, 32'h0);
        idle(2);
        drain(2);

        tick(3);
        done = 1'b1;
    end

    always @(negedge clk) begin
        logic [32:0] e;
        for (int g = 0; g < 3; g++) begin
            if (rst_prev[g]) begin
                checks++;
                if (req_ready[g] !== 1'b1 || rsp_valid[g] !== 1'b0 ||
                    rsp_rdata[g] !== 32'h0 || rsp_err[g] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state dut%0d: got rdy=%b vld=%b rd=%h err=%b, want 1 0 0 0",
                             g, req_ready[g], rsp_valid[g], rsp_rdata[g], rsp_err[g]);
                end
            end
            if (rst[g]) begin
                pend[g]      = 1'b0;
                hs_prev[g]   = 1'b0;
                hold_prev[g] = 1'b0;
                vld_prev[g]  = 1'b0;
            end else begin
                if (hs_prev[g]) begin
                    checks++;
                    if (req_ready[g] !== 1'b1 || rsp_valid[g] !== 1'b0) begin
                        errors++;
                        $display("FAIL post_handshake dut%0d: got rdy=%b vld=%b, want 1 0",
                                 g, req_ready[g], rsp_valid[g]);
                    end
                end
                checks++;
                if (req_ready[g] && rsp_valid[g]) begin
                    errors++;
                    $display("FAIL ready_valid_excl dut%0d: both high at cycle %0d", g, cyc);
                end
                if (pend[g] && !rsp_valid[g]) begin
                    checks++;
                    if (req_ready[g] !== 1'b0) begin
                        errors++;
                        $display("FAIL busy_ready dut%0d: got req_ready=%b, want 0", g, req_ready[g]);
                    end
                end
                if (rsp_valid[g] && !vld_prev[g]) begin
                    checks++;
                    if (!pend[g] || cyc != acc[g] + lat_of(g) - 1) begin
                        errors++;
                        $display("FAIL latency dut%0d: got first valid cycle %0d, want %0d",
                                 g, cyc, acc[g] + lat_of(g) - 1);
                    end
                end
                if (rsp_valid[g] && hold_prev[g]) begin
                    checks++;
                    if (rsp_rdata[g] !== sv_rd[g] || rsp_err[g] !== sv_err[g] ||
                        req_ready[g] !== 1'b0) begin
                        errors++;
                        $display("FAIL hold_stable dut%0d: got rd=%h err=%b rdy=%b, want rd=%h err=%b rdy=0",
                                 g, rsp_rdata[g], rsp_err[g], req_ready[g], sv_rd[g], sv_err[g]);
                    end
                end
                hs_prev[g] = rsp_valid[g] && rsp_ready[g];
                if (hs_prev[g]) begin
                    checks++;
                    pend[g] = 1'b0;
                    if (exp_q[g].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rsp dut%0d: got rd=%h err=%b, want none",
                                 g, rsp_rdata[g], rsp_err[g]);
                    end else begin
                        e = exp_q[g].pop_front();
                        if ({rsp_err[g], rsp_rdata[g]} !== e) begin
                            errors++;
                            $display("FAIL rsp_data dut%0d: got err=%b rd=%h, want err=%b rd=%h",
                                     g, rsp_err[g], rsp_rdata[g], e[32], e[31:0]);
                        end
                    end
                end
                if (req_valid[g] && req_ready[g]) begin
                    acc[g]  = cyc + 1;
                    pend[g] = 1'b1;
                end
                hold_prev[g] = rsp_valid[g] && !rsp_ready[g];
                sv_rd[g]     = rsp_rdata[g];
                sv_err[g]    = rsp_err[g];
                vld_prev[g]  = rsp_valid[g];
            end
            rst_prev[g] = rst[g];
        end
        if (done || cyc > 5000) begin
            if (!done) begin
                errors++;
                $display("FAIL timeout: got cycle %0d, want stimulus complete", cyc);
            end
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (exp_q[g].size() != 0) begin
                    errors++;
                    $display("FAIL leftover dut%0d: got %0d pending, want 0", g, exp_q[g].size());
                end
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

endmodule
